otter_dmem_responder: RTL and testbench

Data-memory responder for the pipelined OTTER core. It answers load/store requests issued by the MEM stage over a valid/ready request channel and returns one-cycle response pulses. It handles sub-word RISC-V access rules (byte lanes, sign extension), error detection, and a configurable number of wait states, so the pipeline can be exercised against a slow memory.

---
 rtl/otter_dmem_responder_if.sv | 23 ++
 rtl/otter_dmem_responder.sv | 143 ++++++++++++++
 tb/tb_otter_dmem_responder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/otter_dmem_responder_if.sv
// Request/response bus between the OTTER MEM stage (master) and the data memory (slave).
interface otter_dmem_responder_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [31:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic        RSP_VALID;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_UNSIGNED,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_UNSIGNED,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );
endinterface

// File: rtl/otter_dmem_responder.sv
// Data-memory responder for the pipelined OTTER core: sub-word loads/stores with
// error detection and a configurable number of wait states before each access.
module otter_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  otter_dmem_responder_if.slave  bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [1:0]       lane;
  logic [IDX_W-1:0] idx;
  logic             err;
  logic             access;
  logic [31:0]      rd_word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      load_data;
  logic [31:0]      wr_word;
  logic [3:0]       wr_be;

  assign bus.REQ_READY = (state == IDLE) && !RST;
  assign bus.RSP_VALID = rsp_valid;
  assign bus.RSP_RDATA = rsp_rdata;
  assign bus.RSP_ERR   = rsp_err;

  // BASE_ADDR is word aligned, so the low offset bits are the byte lane.
  assign offset = addr_q - BASE_ADDR;
  assign lane   = offset[1:0];
  assign idx    = offset[IDX_W+1:2];
  assign access = (state == BUSY) && (cnt == 4'd0);

  assign err = (size_q == 2'b11)
            || ((size_q == 2'b01) && addr_q[0])
            || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
            || (addr_q < BASE_ADDR)
            || ({2'b00, offset[31:2]} >= DEPTH_WORDS);

  assign rd_word  = mem[idx];
  assign byte_sel = rd_word[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    case (size_q)
      2'b00:   load_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      2'b10:   load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_be   = '0;
    wr_word = wdata_q;
    case (size_q)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        wr_be   = lane[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      2'b10:   wr_be = 4'b1111;
      default: wr_be = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (access && we_q && !err && !RST) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.REQ_VALID) begin
            we_q    <= bus.REQ_WE;
            addr_q  <= bus.REQ_ADDR;
            wdata_q <= bus.REQ_WDATA;
            size_q  <= bus.REQ_SIZE;
            uns_q   <= bus.REQ_UNSIGNED;
            cnt     <= 4'(WAIT_STATES);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_err   <= err;
            rsp_rdata <= (err || we_q) ? 32'h0 : load_data;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_dmem_responder.sv
// Randomized self-checking bench for otter_dmem_responder against a byte-level memory model;
// three instances cover WAIT_STATES 1, 0 and 15 (the last with a non-zero base and small depth).
module tb_otter_dmem_responder;

  localparam logic [31:0] BASE2  = 32'h0000_1000;
  localparam int          DEPTH2 = 64;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic [2:0]  req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_model [1024];

  otter_dmem_responder_if bus0();
  otter_dmem_responder_if bus1();
  otter_dmem_responder_if bus2();

  assign bus0.REQ_VALID = req_valid[0];
  assign bus0.REQ_WE = req_we;
  assign bus0.REQ_ADDR = req_addr;
  assign bus0.REQ_WDATA = req_wdata;
  assign bus0.REQ_SIZE = req_size;
  assign bus0.REQ_UNSIGNED = req_unsigned;
  assign bus1.REQ_VALID = req_valid[1];
  assign bus1.REQ_WE = req_we;
  assign bus1.REQ_ADDR = req_addr;
  assign bus1.REQ_WDATA = req_wdata;
  assign bus1.REQ_SIZE = req_size;
  assign bus1.REQ_UNSIGNED = req_unsigned;
  assign bus2.REQ_VALID = req_valid[2];
  assign bus2.REQ_WE = req_we;
  assign bus2.REQ_ADDR = req_addr;
  assign bus2.REQ_WDATA = req_wdata;
  assign bus2.REQ_SIZE = req_size;
  assign bus2.REQ_UNSIGNED = req_unsigned;

  wire [2:0] rdy  = {bus2.REQ_READY, bus1.REQ_READY, bus0.REQ_READY};
  wire [2:0] rspv = {bus2.RSP_VALID, bus1.RSP_VALID, bus0.RSP_VALID};
  wire [2:0] rerr = {bus2.RSP_ERR, bus1.RSP_ERR, bus0.RSP_ERR};

  otter_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1))
    dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
  otter_dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0))
    dut1 (.CLK(CLK), .RST(RST), .bus(bus1));
  otter_dmem_responder #(.DEPTH_WORDS(DEPTH2), .BASE_ADDR(BASE2), .WAIT_STATES(15))
    dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  function automatic int w_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 15;
  endfunction

  function automatic longint base_of(input int k);
    return (k == 2) ? longint'(BASE2) : 64'd0;
  endfunction

  function automatic longint depth_of(input int k);
    return (k == 2) ? longint'(DEPTH2) : 64'd1024;
  endfunction

  function automatic logic [31:0] rdata_of(input int k);
    case (k)
      0:       return bus0.RSP_RDATA;
      1:       return bus1.RSP_RDATA;
      default: return bus2.RSP_RDATA;
    endcase
  endfunction

  // Reference behaviour: byte-granular masks and shifts on a plain word array.
  function automatic void model(input int k, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [1:0] size,
                                input logic uns, output logic [31:0] rd, output logic err);
    longint a = longint'(addr);
    int nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    int off;
    int idx;
    logic [31:0] mask;
    logic [31:0] val;
    rd  = 32'h0;
    err = (size == 2'd3) || (a % nbytes != 0) || (a < base_of(k))
       || ((a - base_of(k)) / 4 >= depth_of(k));
    if (err) return;
    off  = int'(a % 4);
    idx  = int'((a - base_of(k)) / 4);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    if (we) begin
      if (k == 0)
        mem_model[idx] = (mem_model[idx] & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
    end else begin
      val = (mem_model[idx] >> (8 * off)) & mask;
      if (!uns && nbytes < 4 && val[8*nbytes-1]) val = val | ~mask;
      rd = val;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance k, checked for latency, data, pulse width and hold.
  task automatic applyStimulus(input int k, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] size,
                               input logic uns, input string tag);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    int          guard = 0;
    @(negedge CLK);
    while (!rdy[k] && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!rdy[k]) begin
      checkOutput({tag, " ready"}, 32'(rdy[k]), 32'd1);
      return;
    end
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_size = size;
    req_unsigned = uns;
    req_valid[k] = 1'b1;
    model(k, we, addr, wdata, size, uns, exp_d, exp_e);
    @(negedge CLK);
    req_valid[k] = 1'b0;
    req_wdata = $urandom;
    n = 1;
    while (!rspv[k] && n < 40) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(w_of(k) + 2));
    checkOutput({tag, " rdata"}, rdata_of(k), exp_d);
    checkOutput({tag, " err"}, 32'(rerr[k]), 32'(exp_e));
    @(negedge CLK);
    checkOutput({tag, " pulse"}, 32'(rspv[k]), 32'd0);
    checkOutput({tag, " hold"}, rdata_of(k), exp_d);
  endtask

  // REQ_VALID held high: accepts every w+3 edges, one pulse each, READY low while busy.
  task automatic throughput(input int k);
    int w = w_of(k);
    int total = 4 * (w + 3) + 1;
    int last = -1000;
    int accepts = 0;
    int pulses = 0;
    req_we = 1'b1;
    req_addr = 32'(base_of(k)) + 32'h40;
    req_wdata = $urandom;
    req_size = 2'd2;
    req_unsigned = 1'b0;
    @(negedge CLK);
    req_valid[k] = 1'b1;
    for (int c = 0; c < total + w + 3; c++) begin
      if (c > 0) @(negedge CLK);
      if (c == total) req_valid[k] = 1'b0;
      checkOutput("thr rsp_valid", 32'(rspv[k]), 32'(c - last == w + 2));
      if (rspv[k]) begin
        pulses++;
        checkOutput("thr rdata", rdata_of(k), 32'h0);
        checkOutput("thr err", 32'(rerr[k]), 32'd0);
      end
      if (c - last >= 1 && c - last <= w + 2)
        checkOutput("thr ready_low", 32'(rdy[k]), 32'd0);
      if (req_valid[k] && rdy[k]) begin
        if (last >= 0) checkOutput("thr spacing", 32'(c - last), 32'(w + 3));
        last = c;
        accepts++;
      end
    end
    checkOutput("thr accepts", 32'(accepts), 32'd5);
    checkOutput("thr pulses", 32'(pulses), 32'(accepts));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ready"}, 32'(rdy), 32'd0);
    checkOutput({tag, " rsp_valid"}, 32'(rspv), 32'd0);
    checkOutput({tag, " err"}, 32'(rerr), 32'd0);
    checkOutput({tag, " rdata"}, bus0.RSP_RDATA, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] old_data;
    logic [31:0] a;
    RST = 1'b1;
    req_valid = '0;
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    req_size = '0;
    req_unsigned = 1'b0;
    repeat (2) @(negedge CLK);
    checkResetOutputs("reset");
    RST = 1'b0;

    applyStimulus(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 2'd2, 1'b0, "sw 100");
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, "lw 100");
    applyStimulus(0, 1'b0, 32'h103, 32'h0, 2'd0, 1'b0, "lb 103");
    applyStimulus(0, 1'b0, 32'h103, 32'h0, 2'd0, 1'b1, "lbu 103");
    applyStimulus(0, 1'b0, 32'h102, 32'h0, 2'd1, 1'b0, "lh 102");
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 2'd1, 1'b1, "lhu 100");
    applyStimulus(0, 1'b1, 32'h101, 32'h0000_0012, 2'd0, 1'b0, "sb 101");
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, "lw after sb");
    applyStimulus(0, 1'b1, 32'h102, 32'h0000_AB34, 2'd1, 1'b0, "sh 102");
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, "lw after sh");
    checkOutput("plan value", mem_model[64], 32'hAB34_12EF);
    applyStimulus(0, 1'b0, 32'h101, 32'h0, 2'd1, 1'b0, "lh misaligned");
    applyStimulus(0, 1'b1, 32'h102, 32'h1234_5678, 2'd2, 1'b0, "sw misaligned");
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, "lw unchanged");
    applyStimulus(0, 1'b0, 32'h100, 32'h0, 2'd3, 1'b0, "size 11");
    applyStimulus(0, 1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, "lw past end");
    applyStimulus(2, 1'b0, BASE2 - 32'd4, 32'h0, 2'd2, 1'b0, "lw below base");
    applyStimulus(2, 1'b0, BASE2 + 32'(4 * DEPTH2), 32'h0, 2'd2, 1'b0, "lw2 past end");

    for (int i = 0; i < 16; i++)
      applyStimulus(0, 1'b1, 32'h100 + 32'(4 * i), $urandom, 2'd2, 1'b0, "init");
    applyStimulus(0, 1'b1, 32'h200, $urandom, 2'd2, 1'b0, "init 200");
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 32'h1000 + 32'($urandom_range(0, 15))
                                      : 32'h100 + 32'($urandom_range(0, 63));
      applyStimulus(0, 1'(($urandom)), a, $urandom, 2'($urandom), 1'($urandom), "random");
    end

    throughput(1);
    throughput(2);

    old_data = mem_model[128];
    applyStimulus(0, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, "lw 200 before abort");
    @(negedge CLK);
    req_we = 1'b1;
    req_addr = 32'h200;
    req_wdata = ~old_data;
    req_size = 2'd2;
    req_valid[0] = 1'b1;
    @(negedge CLK);
    req_valid[0] = 1'b0;
    #1 RST = 1'b1;
    #1 checkResetOutputs("abort reset");
    @(negedge CLK);
    checkResetOutputs("abort reset held");
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      checkOutput("abort no rsp", 32'(rspv[0]), 32'd0);
    end
    applyStimulus(0, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, "lw 200 after abort");
    checkOutput("abort old data", bus0.RSP_RDATA, old_data);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
